// File: rtl/fx2_des_sequencer_pkg.sv
// Shared op codes, FSM states and header layout for the FX2 -> DES burst sequencer.
package des_seq_pkg;

    localparam int BURST_LEN  = 4;
    localparam int HDR_OP_LSB = 14;
    localparam int HDR_W      = 16;

    typedef enum logic [1:0] {
        OP_KEY = 2'b00,
        OP_ENC = 2'b01,
        OP_DEC = 2'b10,
        OP_BAD = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_FILL,
        ST_BURST,
        ST_DRAIN
    } state_e;

endpackage

// File: rtl/fx2_des_sequencer_credit_cnt.sv
// Up/down saturating credit counter; a decrement at zero is dropped and flagged.
module seq_credit_cnt #(
    parameter int MAX = 2,
    parameter int W   = 2
) (
    input  logic         clk_i,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         at_max,
    output logic         underflow
);

    assign at_max    = (count == W'(MAX));
    assign underflow = dec && (count == '0);

    // Simultaneous inc/dec cancels unless the dec would underflow.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && !(dec && count != '0) && !at_max) begin
            count <= count + W'(1);
        end else if (dec && !inc && count != '0) begin
            count <= count - W'(1);
        end
    end

endmodule

// File: rtl/fx2_des_sequencer.sv
// Frames FX2 FIFO words into header-driven commands and emits credit-throttled
// 4-word bursts to the 16->64 bridge with per-block DES sideband.
module fx2_des_sequencer
    import des_seq_pkg::*;
#(
    parameter int CNT_W   = 14,
    parameter int CREDITS = 2
) (
    input  logic        clk_i,
    input  logic        rst_n,
    input  logic        fifo_empty_n,
    input  logic [15:0] fifo_d,
    output logic        fifo_rd,
    output logic [15:0] br_d,
    output logic        br_en,
    input  logic        des_ack,
    output logic        blk_is_key,
    output logic        blk_decrypt,
    output logic        blk_last,
    output logic        busy,
    output logic        err,
    input  logic        err_clr
);

    localparam int CRW = 2;

    state_e                          state;
    logic [BURST_LEN-1:0][HDR_W-1:0] stage;
    logic [1:0]                      wcnt;
    logic [1:0]                      bcnt;
    logic                            full;
    logic [CNT_W-1:0]                blk_left;
    op_e                             op_q;
    logic [CRW-1:0]                  credits;
    logic                            cr_max, cr_uf, cr_inc;
    logic                            pop, go_burst, err_set;
    op_e                             hdr_op;
    logic [CNT_W-1:0]                hdr_n;

    assign fifo_rd  = (state == ST_HDR) || (state == ST_DRAIN) || (state == ST_FILL && !full);
    assign pop      = fifo_rd && fifo_empty_n;
    assign hdr_op   = op_e'(fifo_d[HDR_OP_LSB +: 2]);
    assign hdr_n    = (hdr_op == OP_KEY) ? CNT_W'(1) : fifo_d[CNT_W-1:0];
    // Launch on the pop that fills the buffer so br_en follows the 4th pop directly.
    assign go_burst = (state == ST_FILL) && !cr_max && (full || (pop && wcnt == 2'd3));
    assign cr_inc   = (state == ST_BURST) && (bcnt == 2'd0);
    assign err_set  = (state == ST_HDR && pop && hdr_op == OP_BAD) || cr_uf;
    assign busy     = (state != ST_IDLE) || (credits != '0);

    seq_credit_cnt #(.MAX(CREDITS), .W(CRW)) u_credit (
        .clk_i     (clk_i),
        .rst_n     (rst_n),
        .inc       (cr_inc),
        .dec       (des_ack),
        .count     (credits),
        .at_max    (cr_max),
        .underflow (cr_uf)
    );

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            stage       <= '0;
            wcnt        <= '0;
            bcnt        <= '0;
            full        <= 1'b0;
            blk_left    <= '0;
            op_q        <= OP_KEY;
            br_d        <= '0;
            br_en       <= 1'b0;
            blk_is_key  <= 1'b0;
            blk_decrypt <= 1'b0;
            blk_last    <= 1'b0;
            err         <= 1'b0;
        end else begin
            if (err_clr)      err <= 1'b0;
            else if (err_set) err <= 1'b1;

            case (state)
                ST_IDLE: if (fifo_empty_n) state <= ST_HDR;
                ST_HDR: if (pop) begin
                    op_q     <= hdr_op;
                    blk_left <= hdr_n;
                    wcnt     <= '0;
                    full     <= 1'b0;
                    if (hdr_n == '0)           state <= ST_IDLE;
                    else if (hdr_op == OP_BAD) state <= ST_DRAIN;
                    else                       state <= ST_FILL;
                end
                ST_FILL: begin
                    if (pop) begin
                        stage[wcnt] <= fifo_d;
                        wcnt        <= wcnt + 2'd1;
                        if (wcnt == 2'd3) full <= 1'b1;
                    end
                    if (go_burst) begin
                        state       <= ST_BURST;
                        br_en       <= 1'b1;
                        br_d        <= stage[0];
                        bcnt        <= '0;
                        blk_is_key  <= (op_q == OP_KEY);
                        blk_decrypt <= (op_q == OP_DEC);
                        blk_last    <= (blk_left == CNT_W'(1));
                    end
                end
                ST_BURST: begin
                    bcnt <= bcnt + 2'd1;
                    if (bcnt == 2'd3) begin
                        br_en    <= 1'b0;
                        br_d     <= '0;
                        full     <= 1'b0;
                        blk_left <= blk_left - CNT_W'(1);
                        state    <= (blk_left == CNT_W'(1)) ? ST_IDLE : ST_FILL;
                    end else begin
                        br_d <= stage[bcnt + 2'd1];
                    end
                end
                ST_DRAIN: if (pop) begin
                    wcnt <= wcnt + 2'd1;
                    if (wcnt == 2'd3) begin
                        blk_left <= blk_left - CNT_W'(1);
                        if (blk_left == CNT_W'(1)) state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fx2_des_sequencer.sv
// Scoreboard bench: stimulus queues expected burst words, a negedge monitor checks them.
module tb_fx2_des_sequencer;

    logic        clk_i = 1'b0;
    logic        rst_n = 1'b0;
    logic        fifo_empty_n = 1'b0;
    logic [15:0] fifo_d = 16'h0;
    logic        fifo_rd;
    logic [15:0] br_d;
    logic        br_en;
    logic        des_ack = 1'b0;
    logic        blk_is_key, blk_decrypt, blk_last, busy, err;
    logic        err_clr = 1'b0;

    typedef struct packed {
        logic [15:0] d;
        logic        key;
        logic        dec;
        logic        last;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] fq[$];
    int          ack_due[$];
    int          errors = 0, checks = 0;
    int          cyc = 0, pops = 0, words_seen = 0, outstanding = 0, run = 0, man_req = 0;
    bit          auto_en = 1'b1;
    exp_t        mon_e;

    fx2_des_sequencer #(.CNT_W(14), .CREDITS(2)) dut (
        .clk_i        (clk_i),
        .rst_n        (rst_n),
        .fifo_empty_n (fifo_empty_n),
        .fifo_d       (fifo_d),
        .fifo_rd      (fifo_rd),
        .br_d         (br_d),
        .br_en        (br_en),
        .des_ack      (des_ack),
        .blk_is_key   (blk_is_key),
        .blk_decrypt  (blk_decrypt),
        .blk_last     (blk_last),
        .busy         (busy),
        .err          (err),
        .err_clr      (err_clr)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Show-ahead FIFO model: a pop decided before the edge takes effect just after it.
    initial begin
        bit pend;
        forever begin
            @(negedge clk_i);
            pend = rst_n && fifo_rd && fifo_empty_n;
            @(posedge clk_i);
            #1;
            if (pend && fq.size() > 0) begin
                void'(fq.pop_front());
                pops++;
            end
            fifo_empty_n = (fq.size() > 0);
            fifo_d       = (fq.size() > 0) ? fq[0] : 16'h0;
        end
    end

    // Monitor: scoreboard compare, burst length, credit ceiling, and des_ack generation.
    initial begin
        forever begin
            @(negedge clk_i);
            cyc++;
            if (!rst_n) begin
                run     = 0;
                des_ack = 1'b0;
            end else begin
                if (br_en) begin
                    if (run == 0) begin
                        chk("credit_limit", 32'(outstanding < 2), 32'd1);
                        outstanding++;
                    end
                    run++;
                    words_seen++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_br_en: got word %h expected no burst", br_d);
                    end else begin
                        mon_e = exp_q.pop_front();
                        chk("br_d", 32'(br_d), 32'(mon_e.d));
                        chk("sideband", {29'd0, blk_is_key, blk_decrypt, blk_last},
                            {29'd0, mon_e.key, mon_e.dec, mon_e.last});
                    end
                end else if (run != 0) begin
                    chk("burst_len", run, 4);
                    run = 0;
                    if (auto_en) ack_due.push_back(cyc + 9);
                end
                des_ack = 1'b0;
                if (ack_due.size() > 0 && ack_due[0] == cyc) begin
                    void'(ack_due.pop_front());
                    des_ack = 1'b1;
                end else if (man_req > 0) begin
                    man_req--;
                    des_ack = 1'b1;
                end
                if (des_ack) outstanding--;
            end
        end
    end

    function automatic logic [15:0] word_of(input logic [15:0] base, input int b, input int w);
        return base + 16'(b * 16) + 16'(w * 16'h4444);
    endfunction

    task automatic send(input logic [15:0] hdr, input int nblk, input logic [15:0] base,
                        input bit key, input bit dec, input bit expect_out);
        exp_t e;
        fq.push_back(hdr);
        for (int b = 0; b < nblk; b++) begin
            for (int w = 0; w < 4; w++) begin
                fq.push_back(word_of(base, b, w));
                if (expect_out) begin
                    e.d = word_of(base, b, w); e.key = key; e.dec = dec; e.last = (b == nblk - 1);
                    exp_q.push_back(e);
                end
            end
        end
    endtask

    task automatic wait_idle(input string name, input int limit);
        int i = 0;
        repeat (3) @(negedge clk_i);
        while ((busy || exp_q.size() != 0 || ack_due.size() != 0) && i < limit) begin
            @(negedge clk_i);
            i++;
        end
        chk({name, "_idle_timeout"}, 32'(i < limit), 32'd1);
    endtask

    task automatic wait_words(input string name, input int target, input int limit);
        int i = 0;
        while (words_seen < target && i < limit) begin
            @(negedge clk_i);
            i++;
        end
        chk({name, "_words"}, words_seen, target);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, w0, i;
        // Reset state
        @(negedge clk_i);
        chk("rst_br_en", 32'(br_en), 0);
        chk("rst_fifo_rd", 32'(fifo_rd), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_sideband", {29'd0, blk_is_key, blk_decrypt, blk_last}, 0);
        chk("rst_br_d", 32'(br_d), 0);
        @(negedge clk_i);
        rst_n = 1'b1;
        repeat (2) @(negedge clk_i);

        // Key load: word order and key/last sideband
        send(16'h0000, 1, 16'h0123, 1'b1, 1'b0, 1'b1);
        wait_idle("key", 200);

        // 3-block encrypt with delayed acks
        send(16'h4003, 3, 16'h1000, 1'b0, 1'b0, 1'b1);
        wait_idle("enc3", 400);
        chk("enc3_sideband_hold_dec", 32'(blk_decrypt), 0);

        // Decrypt with no acks: stalls before the 3rd burst with the buffer full
        auto_en = 1'b0;
        p0 = pops; w0 = words_seen;
        send(16'h8003, 3, 16'h2000, 1'b0, 1'b1, 1'b1);
        wait_words("dec_first2", w0 + 8, 200);
        repeat (30) @(negedge clk_i);
        chk("dec_stall_words", words_seen - w0, 8);
        chk("dec_stall_pops", pops - p0, 13);
        chk("dec_stall_busy", 32'(busy), 1);
        chk("dec_stall_fifo_rd", 32'(fifo_rd), 0);
        man_req = 1;
        wait_words("dec_third", w0 + 12, 100);
        man_req = 2;
        auto_en = 1'b1;
        wait_idle("dec3", 200);

        // Illegal op: drain payload, flag error, clear it
        p0 = pops; w0 = words_seen;
        send(16'hC001, 1, 16'h3000, 1'b0, 1'b0, 1'b0);
        wait_idle("bad", 200);
        repeat (2) @(negedge clk_i);
        chk("bad_err", 32'(err), 1);
        chk("bad_pops", pops - p0, 5);
        chk("bad_no_burst", words_seen - w0, 0);
        err_clr = 1'b1;
        @(negedge clk_i);
        err_clr = 1'b0;
        chk("err_clr", 32'(err), 0);

        // FIFO runs dry after 2 payload words
        w0 = words_seen;
        fq.push_back(16'h4001);
        fq.push_back(16'hA001);
        fq.push_back(16'hA002);
        repeat (20) @(negedge clk_i);
        chk("starve_no_burst", words_seen - w0, 0);
        chk("starve_fifo_rd", 32'(fifo_rd), 1);
        begin
            exp_t e;
            e.key = 1'b0; e.dec = 1'b0; e.last = 1'b1;
            e.d = 16'hA001; exp_q.push_back(e);
            e.d = 16'hA002; exp_q.push_back(e);
            e.d = 16'hA003; exp_q.push_back(e); fq.push_back(16'hA003);
            e.d = 16'hA004; exp_q.push_back(e); fq.push_back(16'hA004);
        end
        wait_idle("starve", 200);

        // Reset in the 2nd burst cycle
        send(16'h0000, 1, 16'h0123, 1'b1, 1'b0, 1'b1);
        i = 0;
        while (!br_en && i < 100) begin
            @(negedge clk_i);
            i++;
        end
        chk("rst_burst_started", 32'(br_en), 1);
        @(posedge clk_i);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_br_en", 32'(br_en), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_fifo_rd", 32'(fifo_rd), 0);
        exp_q.delete(); fq.delete(); ack_due.delete();
        outstanding = 0; man_req = 0;
        repeat (2) @(negedge clk_i);
        rst_n = 1'b1;
        repeat (2) @(negedge clk_i);

        // Realigned after reset
        send(16'h0000, 1, 16'h0123, 1'b1, 1'b0, 1'b1);
        wait_idle("post_rst", 200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
